// File: rtl/ex_stage_mdu_pkg.sv
// Shared encodings for the execute stage and its multiply/divide unit.
// MDU_EARLY_OUT_EN (optional) enables one-step completion for trivial MDU operands.
package ex_stage_mdu_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'b000,
        MD_MULT  = 3'b001,
        MD_MULTU = 3'b010,
        MD_DIV   = 3'b011,
        MD_DIVU  = 3'b100,
        MD_MFHI  = 3'b101,
        MD_MFLO  = 3'b110,
        MD_RSVD  = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        FWD_RF   = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10,
        FWD_RF2  = 2'b11
    } fwd_sel_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_BUSY = 2'b01,
        MDU_DONE = 2'b10
    } mdu_state_e;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
        ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
    } alu_ctrl_e;

    function automatic int mdu_iter_count(input int nbits, input int steps);
        return nbits / steps;
    endfunction

endpackage

// File: rtl/ex_stage_mdu_iter.sv
// Iterative multiply/divide unit: FSM, step counter, HI/LO and shift-add / restoring-divide datapath.
// MDU_EARLY_OUT_EN: zero multiplicands and divisors larger than the dividend finish after one step.
module mdu_iter
    import ex_stage_mdu_pkg::*;
#(
    parameter int NBits     = 32,
    parameter int MDU_STEPS = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             flush_i,
    input  md_op_e           op_i,
    input  logic [NBits-1:0] a_i,
    input  logic [NBits-1:0] b_i,
    output logic [NBits-1:0] hi_o,
    output logic [NBits-1:0] lo_o,
    output logic             stall_o,
    output logic             busy_o
);
    localparam int ITER = mdu_iter_count(NBits, MDU_STEPS);
    localparam int CW   = $clog2(ITER + 1);

    mdu_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [NBits-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [NBits-1:0] acc_q, acc_d, sh_q, sh_d;
    logic [NBits-1:0] opd_q, opd_d, araw_q, araw_d;
    logic div_q, div_d, qneg_q, qneg_d, rneg_q, rneg_d;
    logic dz_q, dz_d, early_q, early_d;

    logic is_div, is_sgn, sa, sb, early;
    logic [NBits-1:0] mag_a, mag_b;

    assign is_div = (op_i == MD_DIV) || (op_i == MD_DIVU);
    assign is_sgn = (op_i == MD_MULT) || (op_i == MD_DIV);
    assign sa     = is_sgn & a_i[NBits-1];
    assign sb     = is_sgn & b_i[NBits-1];
    assign mag_a  = sa ? -a_i : a_i;
    assign mag_b  = sb ? -b_i : b_i;

`ifdef MDU_EARLY_OUT_EN
    assign early = is_div ? (mag_b > mag_a)
                          : ((mag_a == '0) || (mag_b == '0));
`else
    assign early = 1'b0;
`endif

    // acc holds product-high / remainder, sh holds multiplier / quotient
    logic [NBits-1:0] acc_s, sh_s;
    logic [NBits:0]   sum, rem;

    always_comb begin
        acc_s = acc_q;
        sh_s  = sh_q;
        sum   = '0;
        rem   = '0;
        for (int i = 0; i < MDU_STEPS; i++) begin
            if (div_q) begin
                rem  = {acc_s, sh_s[NBits-1]};
                sh_s = {sh_s[NBits-2:0], 1'b0};
                if (rem >= {1'b0, opd_q}) begin
                    rem     = rem - {1'b0, opd_q};
                    sh_s[0] = 1'b1;
                end
                acc_s = rem[NBits-1:0];
            end else begin
                sum   = {1'b0, acc_s} + (sh_s[0] ? {1'b0, opd_q} : {(NBits+1){1'b0}});
                sh_s  = {sum[0], sh_s[NBits-1:1]};
                acc_s = sum[NBits:1];
            end
        end
    end

    logic [2*NBits-1:0] prod, prod_s;
    logic [NBits-1:0]   quo, rmd, quo_s, rmd_s;

    always_comb begin
        prod   = early_q ? '0 : {acc_s, sh_s};
        prod_s = qneg_q ? -prod : prod;
        quo    = early_q ? '0 : sh_s;
        rmd    = early_q ? sh_q : acc_s;
        quo_s  = qneg_q ? -quo : quo;
        rmd_s  = rneg_q ? -rmd : rmd;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        acc_d   = acc_q;
        sh_d    = sh_q;
        opd_d   = opd_q;
        araw_d  = araw_q;
        div_d   = div_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        early_d = early_q;
        unique case (state_q)
            MDU_IDLE: begin
                if (start_i) begin
                    acc_d   = '0;
                    sh_d    = is_div ? mag_a : mag_b;
                    opd_d   = is_div ? mag_b : mag_a;
                    araw_d  = a_i;
                    div_d   = is_div;
                    qneg_d  = sa ^ sb;
                    rneg_d  = sa;
                    dz_d    = is_div && (b_i == '0);
                    early_d = early;
                    cnt_d   = early ? CW'(1) : CW'(ITER);
                    state_d = MDU_BUSY;
                end
            end
            MDU_BUSY: begin
                acc_d = acc_s;
                sh_d  = sh_s;
                cnt_d = cnt_q - CW'(1);
                if (flush_i) begin
                    state_d = MDU_IDLE;
                end else if (cnt_q == CW'(1)) begin
                    state_d = MDU_DONE;
                    if (!div_q) begin
                        {hi_d, lo_d} = prod_s;
                    end else if (dz_q) begin
                        hi_d = araw_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rmd_s;
                        lo_d = quo_s;
                    end
                end
            end
            MDU_DONE: state_d = MDU_IDLE;
            default:  state_d = MDU_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            acc_q   <= '0;
            sh_q    <= '0;
            opd_q   <= '0;
            araw_q  <= '0;
            div_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            early_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            acc_q   <= acc_d;
            sh_q    <= sh_d;
            opd_q   <= opd_d;
            araw_q  <= araw_d;
            div_q   <= div_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            early_q <= early_d;
        end
    end

    assign hi_o    = hi_q;
    assign lo_o    = lo_q;
    assign stall_o = rst_ni & (((state_q == MDU_IDLE) & start_i) | (state_q == MDU_BUSY));
    assign busy_o  = rst_ni & (state_q == MDU_BUSY);

endmodule

// File: rtl/ex_stage_mdu.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution and the iterative MDU.
// MDU_EARLY_OUT_EN (optional) shortens trivial MULT/DIV operations inside mdu_iter.
module ex_stage_mdu
    import ex_stage_mdu_pkg::*;
#(
    parameter int NBits     = 32,
    parameter int MDU_STEPS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             flush,
    input  logic [2:0]       alu_op,
    input  logic [5:0]       alu_function,
    input  logic [2:0]       md_op,
    input  logic             alu_src,
    input  logic             shamt_sel,
    input  logic             beq,
    input  logic             bne,
    input  logic             jump,
    input  logic             jr,
    input  logic [1:0]       fwd_a,
    input  logic [1:0]       fwd_b,
    input  logic [NBits-1:0] read_data1,
    input  logic [NBits-1:0] read_data2,
    input  logic [NBits-1:0] shamt_ext,
    input  logic [NBits-1:0] imm_ext,
    input  logic [NBits-1:0] pc_4,
    input  logic [25:0]      jump_target,
    input  logic [NBits-1:0] wb_data,
    input  logic [NBits-1:0] mem_alu_result,
    output logic [NBits-1:0] ex_result,
    output logic [NBits-1:0] write_data,
    output logic [NBits-1:0] new_pc,
    output logic             pc_redirect,
    output logic             stall,
    output logic             mdu_busy
);
    localparam int SW = $clog2(NBits);

    logic [NBits-1:0] fa, fb, op_a, op_b, alu_res, mdu_hi, mdu_lo;
    alu_ctrl_e alu_ctrl;
    logic zero, taken, md_start;

    always_comb begin
        case (fwd_sel_e'(fwd_a))
            FWD_WB:  fa = wb_data;
            FWD_MEM: fa = mem_alu_result;
            default: fa = read_data1;
        endcase
        case (fwd_sel_e'(fwd_b))
            FWD_WB:  fb = wb_data;
            FWD_MEM: fb = mem_alu_result;
            default: fb = read_data2;
        endcase
    end

    assign op_a       = shamt_sel ? shamt_ext : fa;
    assign op_b       = alu_src ? imm_ext : fb;
    assign write_data = fb;

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            3'b000: alu_ctrl = ALU_ADD;
            3'b001: alu_ctrl = ALU_SUB;
            3'b011: alu_ctrl = ALU_AND;
            3'b100: alu_ctrl = ALU_OR;
            3'b101: alu_ctrl = ALU_XOR;
            3'b110: alu_ctrl = ALU_SLT;
            3'b111: alu_ctrl = ALU_LUI;
            default: begin
                case (alu_function)
                    6'b100010, 6'b100011: alu_ctrl = ALU_SUB;
                    6'b100100: alu_ctrl = ALU_AND;
                    6'b100101: alu_ctrl = ALU_OR;
                    6'b100110: alu_ctrl = ALU_XOR;
                    6'b100111: alu_ctrl = ALU_NOR;
                    6'b101010: alu_ctrl = ALU_SLT;
                    6'b101011: alu_ctrl = ALU_SLTU;
                    6'b000000, 6'b000100: alu_ctrl = ALU_SLL;
                    6'b000010, 6'b000110: alu_ctrl = ALU_SRL;
                    6'b000011, 6'b000111: alu_ctrl = ALU_SRA;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (alu_ctrl)
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_NOR:  alu_res = ~(op_a | op_b);
            ALU_SLT:  alu_res = {{(NBits-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: alu_res = {{(NBits-1){1'b0}}, op_a < op_b};
            ALU_SLL:  alu_res = op_b << op_a[SW-1:0];
            ALU_SRL:  alu_res = op_b >> op_a[SW-1:0];
            ALU_SRA:  alu_res = NBits'($signed(op_b) >>> op_a[SW-1:0]);
            ALU_LUI:  alu_res = {op_b[NBits-17:0], 16'b0};
            default:  alu_res = op_a + op_b;
        endcase
    end

    assign md_start = in_valid & ~flush
                    & (md_op_e'(md_op) inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU});

    mdu_iter #(
        .NBits     (NBits),
        .MDU_STEPS (MDU_STEPS)
    ) u_mdu (
        .clk_i   (clk),
        .rst_ni  (reset),
        .start_i (md_start),
        .flush_i (flush),
        .op_i    (md_op_e'(md_op)),
        .a_i     (fa),
        .b_i     (fb),
        .hi_o    (mdu_hi),
        .lo_o    (mdu_lo),
        .stall_o (stall),
        .busy_o  (mdu_busy)
    );

    always_comb begin
        ex_result = alu_res;
        case (md_op_e'(md_op))
            MD_MFHI: ex_result = mdu_hi;
            MD_MFLO: ex_result = mdu_lo;
            default: ex_result = alu_res;
        endcase
    end

    assign zero  = (alu_res == '0);
    assign taken = (beq & zero) | (bne & ~zero);

    // jr deliberately uses the unforwarded register value
    always_comb begin
        if (jr)
            new_pc = read_data1;
        else if (taken)
            new_pc = pc_4 + (imm_ext << 2);
        else
            new_pc = {pc_4[NBits-1:28], jump_target, 2'b00};
    end

    assign pc_redirect = reset & in_valid & ~flush & ~stall & (jump | jr | taken);

endmodule

// File: tb/tb_ex_stage_mdu.sv
// Bench for ex_stage_mdu: directed and random MDU ops against an arithmetic model, plus branch/ALU checks.
// Expected MDU latency follows MDU_EARLY_OUT_EN when the build defines it.
module tb_ex_stage_mdu;
    localparam int N    = 32;
    localparam int ITER = 32;

    logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0, flush = 1'b0;
    logic [2:0] alu_op = '0, md_op = '0;
    logic [5:0] alu_function = '0;
    logic alu_src = 1'b0, shamt_sel = 1'b0, beq = 1'b0, bne = 1'b0, jump = 1'b0, jr = 1'b0;
    logic [1:0] fwd_a = '0, fwd_b = '0;
    logic [N-1:0] read_data1 = '0, read_data2 = '0, shamt_ext = '0, imm_ext = '0, pc_4 = '0;
    logic [N-1:0] wb_data = '0, mem_alu_result = '0;
    logic [25:0] jump_target = '0;
    logic [N-1:0] ex_result, write_data, new_pc;
    logic pc_redirect, stall, mdu_busy;

    int checks = 0, errors = 0;
    logic [63:0] hl_exp = '0;

    ex_stage_mdu #(.NBits(N), .MDU_STEPS(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .flush(flush),
        .alu_op(alu_op), .alu_function(alu_function), .md_op(md_op),
        .alu_src(alu_src), .shamt_sel(shamt_sel), .beq(beq), .bne(bne),
        .jump(jump), .jr(jr), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .read_data1(read_data1), .read_data2(read_data2), .shamt_ext(shamt_ext),
        .imm_ext(imm_ext), .pc_4(pc_4), .jump_target(jump_target),
        .wb_data(wb_data), .mem_alu_result(mem_alu_result),
        .ex_result(ex_result), .write_data(write_data), .new_pc(new_pc),
        .pc_redirect(pc_redirect), .stall(stall), .mdu_busy(mdu_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        res = '0;
        if (op == 3'd1) begin
            sa  = longint'(signed'(a));
            sb  = longint'(signed'(b));
            res = sa * sb;
        end else if (op == 3'd2) begin
            res = {32'b0, a} * {32'b0, b};
        end else if (b == 32'd0) begin
            res = {a, 32'hFFFF_FFFF};
        end else begin
            sa  = (op == 3'd3) ? longint'(signed'(a)) : longint'({32'b0, a});
            sb  = (op == 3'd3) ? longint'(signed'(b)) : longint'({32'b0, b});
            q   = sa / sb;
            r   = sa % sb;
            res = {r[31:0], q[31:0]};
        end
        return res;
    endfunction

    function automatic int exp_cycles(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_EARLY_OUT_EN
        longint ma, mb;
        bit sg;
        sg = (op == 3'd1) || (op == 3'd3);
        ma = sg ? longint'(signed'(a)) : longint'({32'b0, a});
        mb = sg ? longint'(signed'(b)) : longint'({32'b0, b});
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
        if (op <= 3'd2) begin
            if (ma == 0 || mb == 0) return 2;
        end else if (mb != 0 && mb > ma) begin
            return 2;
        end
`endif
        return ITER + 1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // called just after a rising edge; leaves just after a rising edge
    task automatic read_hilo(input string tag, input logic [63:0] exp);
        in_valid = 1'b1;
        md_op    = 3'b101;
        @(negedge clk);
        chk({tag, "_hi"}, {32'b0, ex_result}, {32'b0, exp[63:32]});
        @(posedge clk); #1;
        md_op = 3'b110;
        @(negedge clk);
        chk({tag, "_lo"}, {32'b0, ex_result}, {32'b0, exp[31:0]});
        @(posedge clk); #1;
        in_valid = 1'b0;
        md_op    = 3'b000;
    endtask

    task automatic run_core(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input string tag);
        int cyc;
        hl_exp   = model(op, a, b);
        in_valid = 1'b1;
        md_op    = op;
        cyc      = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!stall) break;
            cyc++;
            @(posedge clk); #1;
        end
        chk({tag, "_stall"}, 64'(cyc), 64'(exp_cycles(op, a, b)));
        @(posedge clk); #1;
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        read_hilo(tag, hl_exp);
    endtask

    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        fwd_a      = 2'b00;
        fwd_b      = 2'b00;
        read_data1 = a;
        read_data2 = b;
        run_core(op, a, b, tag);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  rop;

        in_valid = 1'b1;
        md_op    = 3'b001;
        jump     = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {63'b0, stall}, 64'd0);
        chk("rst_busy", {63'b0, mdu_busy}, 64'd0);
        chk("rst_redirect", {63'b0, pc_redirect}, 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        md_op    = 3'b000;
        jump     = 1'b0;
        reset    = 1'b1;
        read_hilo("rst", 64'd0);

        run_md(3'b010, 32'hFFFF_FFFF, 32'd2, "multu_max");
        run_md(3'b011, 32'hFFFF_FFF9, 32'd2, "div_neg7_2");
        run_md(3'b100, 32'd10, 32'd0, "divu_by0");
        run_md(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_md(3'b011, 32'hFFFF_FFF0, 32'd0, "div_by0_neg");

        fwd_a          = 2'b10;
        mem_alu_result = 32'd5;
        read_data1     = 32'hDEAD_BEEF;
        read_data2     = 32'hFFFF_FFFD;
        run_core(3'b001, 32'd5, 32'hFFFF_FFFD, "mult_fwd");

        read_data1 = 32'd3;
        read_data2 = 32'd4;
        in_valid   = 1'b1;
        md_op      = 3'b001;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        chk("flush_busy_stall", {63'b0, stall}, 64'd1);
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        md_op    = 3'b000;
        @(negedge clk);
        chk("flush_stall", {63'b0, stall}, 64'd0);
        chk("flush_busy", {63'b0, mdu_busy}, 64'd0);
        @(posedge clk); #1;
        read_hilo("flush_keep", hl_exp);

        read_data1 = 32'd7;
        read_data2 = 32'd9;
        in_valid   = 1'b1;
        md_op      = 3'b010;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        jump  = 1'b1;
        @(negedge clk);
        chk("rstmid_stall", {63'b0, stall}, 64'd0);
        chk("rstmid_redirect", {63'b0, pc_redirect}, 64'd0);
        @(posedge clk); #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        md_op    = 3'b000;
        jump     = 1'b0;
        @(negedge clk);
        chk("rstmid_busy", {63'b0, mdu_busy}, 64'd0);
        @(posedge clk); #1;
        hl_exp = '0;
        read_hilo("rstmid", hl_exp);

        in_valid   = 1'b1;
        md_op      = 3'b001;
        alu_op     = 3'b001;
        beq        = 1'b1;
        read_data1 = 32'd5;
        read_data2 = 32'd5;
        imm_ext    = 32'd3;
        pc_4       = 32'h0000_1000;
        @(negedge clk);
        chk("beq_stalled_stall", {63'b0, stall}, 64'd1);
        chk("beq_stalled_redirect", {63'b0, pc_redirect}, 64'd0);
        #1 md_op = 3'b000;
        #1;
        chk("beq_redirect", {63'b0, pc_redirect}, 64'd1);
        chk("beq_target", {32'b0, new_pc}, 64'h0000_100C);
        beq = 1'b0;
        bne = 1'b1;
        #1;
        chk("bne_eq_redirect", {63'b0, pc_redirect}, 64'd0);
        bne         = 1'b0;
        jump        = 1'b1;
        pc_4        = 32'hA000_0004;
        jump_target = 26'h123456;
        #1;
        chk("j_target", {32'b0, new_pc}, 64'hA048_D158);
        jump       = 1'b0;
        jr         = 1'b1;
        read_data1 = 32'h0000_4000;
        fwd_a      = 2'b01;
        wb_data    = 32'h0000_0777;
        #1;
        chk("jr_target", {32'b0, new_pc}, 64'h0000_4000);
        jr         = 1'b0;
        alu_op     = 3'b000;
        alu_src    = 1'b1;
        imm_ext    = 32'hFFFF_FFFC;
        fwd_b      = 2'b01;
        #1;
        chk("addi_fwd", {32'b0, ex_result}, 64'h0000_0773);
        chk("store_fwd", {32'b0, write_data}, 64'h0000_0777);
        @(posedge clk); #1;
        in_valid = 1'b0;
        alu_src  = 1'b0;
        fwd_a    = 2'b00;
        fwd_b    = 2'b00;

        run_md(3'b010, 32'd0, 32'd123, "multu_zero");
        run_md(3'b100, 32'd5, 32'd100, "divu_small");

        for (int i = 0; i < 16; i++) begin
            rop = 3'($urandom_range(1, 4));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: ra = 32'd0;
                2: rb = 32'($urandom_range(1, 300));
                3: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                default: ;
            endcase
            run_md(rop, ra, rb, $sformatf("rnd%0d_op%0d", i, rop));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
